div_iterative_unit: RTL and testbench
=====================================

# div_iterative_unit

Radix-2 restoring integer divider that sits directly downstream of the divider input FIFO. It pops one request at a time from the FIFO's valid/pop interface and computes one quotient bit per cycle. It applies RISC-V M-extension sign and divide-by-zero rules and holds the result on a valid/ack writeback port until it is accepted. It is non-pipelined: at most one request is in flight.

## Interface
- XLEN, 32: operand and result width.
- ID_WIDTH, 3: width of the instruction tag carried through unchanged.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  FIFO has an entry; in_dividend/in_divisor/in_op/in_id are valid this cycle.
- in_dividend  in  XLEN  rs1.
- in_divisor  in  XLEN  rs2.
- in_op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU.
- in_id  in  ID_WIDTH  tag.
- in_pop  out  1  combinational; consumes the FIFO head this cycle.
- wb_valid  out  1  result available.
- wb_rd  out  XLEN  quotient or remainder, selected by the latched op.
- wb_id  out  ID_WIDTH  tag of the result.
- wb_ack  in  1  result accepted this cycle; ignored when wb_valid=0.

## Operation
- States: IDLE, BUSY, DONE.
- in_pop = in_valid & (state==IDLE | (state==DONE & wb_ack)) & ~rst.
- Pop cycle:
  - Latch the op and id.
  - Signed ops: take operand magnitudes (two's complement). Record neg_q = sign(dividend)^sign(divisor) and neg_r = sign(dividend).
  - Unsigned ops: neg_q = neg_r = 0.
  - Clear the partial remainder. Load the dividend magnitude into the quotient shift register. Set the iteration counter to XLEN-1.
- Divisor == 0 at pop: next state is DONE directly (fast path). Result: quotient = all ones (both signed and unsigned); remainder = original dividend, unmodified.
- Otherwise next state is BUSY. Each BUSY cycle does one restoring step:
  - Shift {rem, quo} left by 1.
  - Trial subtract the divisor magnitude from rem (XLEN+1-bit subtract).
  - If no borrow: rem = difference and the quotient LSB = 1. Else the quotient LSB = 0.
  - Decrement the counter. When the counter reaches 0, the next state is DONE.
- Entering DONE:
  - Register wb_rd = op[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo).
  - The signed overflow case (-2^(XLEN-1) / -1) falls out naturally: quotient 0x80000000, remainder 0. It needs no special path.
- DONE:
  - Hold wb_valid=1 and keep wb_rd/wb_id stable until wb_ack.
  - On wb_ack with in_valid: pop the next request in the same cycle and go to BUSY, or to DONE if the divisor is 0.
  - On wb_ack without in_valid: go to IDLE.
- The block never pops while BUSY, or while in DONE without wb_ack.

## Timing
- Reset values: state=IDLE, wb_valid=0, wb_rd=0, wb_id=0, counter=0. in_pop=0 during reset.
- Reset mid-operation: the in-flight request is discarded. There is no wb_valid pulse, and the FIFO is not popped while rst=1.
- Pop at cycle T with a nonzero divisor: BUSY during T+1..T+XLEN, wb_valid=1 from T+XLEN+1. Latency is XLEN+1 cycles, i.e. 33 cycles for XLEN=32.
- Pop at cycle T with a zero divisor: wb_valid=1 at T+1.
- Throughput with wb_ack tied high: one result per XLEN+1 cycles, with no idle bubble between requests.
- wb_valid deasserts the cycle after wb_ack, unless a fast-path request popped at ack completes at that same edge.
- All outputs except in_pop are registered.

## Test plan
- DIVU 100/7, then REMU 100/7, wb_ack=1: wb_rd=14 at pop+33, then wb_rd=2 at pop+33 of the second request. in_pop asserts on the ack cycle of the first result.
- DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; DIV 7/-2 gives 0xFFFFFFFD; REM 7/-2 gives 1.
- Divide by zero:
  - DIVU 5/0: wb_rd=0xFFFFFFFF at pop+1.
  - REM -5/0: wb_rd=0xFFFFFFFB at pop+1.
  - DIV -5/0: wb_rd=0xFFFFFFFF at pop+1.
- Overflow: DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0.
- Backpressure: hold wb_ack=0 for 10 cycles with in_valid=1. wb_rd and wb_id stay stable and in_pop stays 0. When wb_ack rises, in_pop=1 in that cycle.
- Reset mid-operation: assert rst at pop+10 for one cycle. wb_valid stays 0. The next request after reset completes with the correct result at its own pop+33.

Source files
------------

// File: rtl/div_iterative_unit.sv
// div_iterative_unit: radix-2 restoring divider, one quotient bit per cycle.
// Pops one request from the divider FIFO and holds the result on the writeback port until acked.
// Applies RISC-V M-extension sign and divide-by-zero rules; only one request in flight.
module div_iterative_unit #(
    parameter int XLEN     = 32,
    parameter int ID_WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    input  logic [XLEN-1:0]     in_dividend_i,
    input  logic [XLEN-1:0]     in_divisor_i,
    input  logic [1:0]          in_op_i,
    input  logic [ID_WIDTH-1:0] in_id_i,
    output logic                in_pop_o,
    output logic                wb_valid_o,
    output logic [XLEN-1:0]     wb_rd_o,
    output logic [ID_WIDTH-1:0] wb_id_o,
    input  logic                wb_ack_i
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic [XLEN-1:0]       rem_q, rem_d;
    logic [XLEN-1:0]       quo_q, quo_d;
    logic [XLEN-1:0]       dvs_q, dvs_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            op_q, op_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  neg_q_q, neg_q_d;
    logic                  neg_r_q, neg_r_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]       wb_rd_q, wb_rd_d;
    logic [ID_WIDTH-1:0]   wb_id_q, wb_id_d;

    // Operand decode at the FIFO head: DIV and REM (op[0]=0) are the signed ops.
    logic                  is_signed;
    logic                  sign_a, sign_b;
    logic [XLEN-1:0]       mag_a, mag_b;
    assign is_signed = ~in_op_i[0];
    assign sign_a    = is_signed & in_dividend_i[XLEN-1];
    assign sign_b    = is_signed & in_divisor_i[XLEN-1];
    assign mag_a     = sign_a ? -in_dividend_i : in_dividend_i;
    assign mag_b     = sign_b ? -in_divisor_i  : in_divisor_i;

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor with a spare borrow bit.
    logic [XLEN+1:0]       shifted, diff;
    logic                  borrow;
    logic [XLEN-1:0]       rem_step, quo_step;
    assign shifted  = {1'b0, rem_q, quo_q[XLEN-1]};
    assign diff     = shifted - {2'b00, dvs_q};
    assign borrow   = diff[XLEN+1];
    assign rem_step = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_step = {quo_q[XLEN-2:0], ~borrow};

    function automatic logic [XLEN-1:0] pickResult(input logic [1:0] op, input logic nq,
                                                   input logic nr, input logic [XLEN-1:0] r,
                                                   input logic [XLEN-1:0] q);
        if (op[1]) return nr ? -r : r;
        return nq ? -q : q;
    endfunction

    // Next-state logic: iterate in BUSY, hold in DONE, and load a new request whenever the FIFO is popped.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        id_d       = id_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_id_d    = wb_id_q;

        in_pop_o = in_valid_i & ((state_q == IDLE) | ((state_q == DONE) & wb_ack_i)) & ~rst;

        case (state_q)
            BUSY: begin
                rem_d = rem_step;
                quo_d = quo_step;
                if (cnt_q == '0) begin
                    state_d    = DONE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = pickResult(op_q, neg_q_q, neg_r_q, rem_step, quo_step);
                    wb_id_d    = id_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (wb_ack_i) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (in_pop_o) begin
            op_d    = in_op_i;
            id_d    = in_id_i;
            neg_q_d = sign_a ^ sign_b;
            neg_r_d = sign_a;
            rem_d   = '0;
            quo_d   = mag_a;
            dvs_d   = mag_b;
            cnt_d   = CW'(XLEN - 1);
            if (in_divisor_i == '0) begin
                state_d    = DONE;
                wb_valid_d = 1'b1;
                wb_rd_d    = in_op_i[1] ? in_dividend_i : '1;
                wb_id_d    = in_id_i;
            end else begin
                state_d    = BUSY;
                wb_valid_d = 1'b0;
            end
        end
    end

    // State register with synchronous reset that drops any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            id_q       <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            id_q       <= id_d;
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_id_q    <= wb_id_d;
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_id_o    = wb_id_q;

endmodule

// File: tb/tb_div_iterative_unit.sv
// tb_div_iterative_unit: directed self-checking bench for the iterative divider.
module tb_div_iterative_unit;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_dividend = '0;
    logic [31:0] in_divisor = '0;
    logic [1:0]  in_op = '0;
    logic [2:0]  in_id = '0;
    logic        in_pop;
    logic        wb_valid;
    logic [31:0] wb_rd;
    logic [2:0]  wb_id;
    logic        wb_ack = 1'b0;

    int compared = 0;
    int mismatched = 0;

    div_iterative_unit #(.XLEN(32), .ID_WIDTH(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid),
        .in_dividend_i(in_dividend),
        .in_divisor_i (in_divisor),
        .in_op_i      (in_op),
        .in_id_i      (in_id),
        .in_pop_o     (in_pop),
        .wb_valid_o   (wb_valid),
        .wb_rd_o      (wb_rd),
        .wb_id_o      (wb_id),
        .wb_ack_i     (wb_ack)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case something wedges the sequence.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] id);
        in_valid    = 1'b1;
        in_op       = op;
        in_dividend = a;
        in_divisor  = b;
        in_id       = id;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until wb_valid is seen, bounded.
    task automatic waitResult(output int edges);
        edges = 0;
        while (!wb_valid && edges < 100) begin
            nextCycle();
            edges++;
        end
    endtask

    // Pop one request from idle, check latency/result/tag, then acknowledge it.
    task automatic doOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] id, input logic [31:0] expRd);
        int edges;
        int expEdges;
        expEdges = (b == 0) ? 0 : 32;
        applyStimulus(op, a, b, id);
        wb_ack = 1'b0;
        #1;
        checkOutput({tag, ".pop"}, 64'(in_pop), 64'd1);
        nextCycle();
        in_valid = 1'b0;
        waitResult(edges);
        checkOutput({tag, ".latency"}, 64'(edges), 64'(expEdges));
        checkOutput({tag, ".rd"}, 64'(wb_rd), 64'(expRd));
        checkOutput({tag, ".id"}, 64'(wb_id), 64'(id));
        wb_ack = 1'b1;
        nextCycle();
        wb_ack = 1'b0;
        checkOutput({tag, ".validDrop"}, 64'(wb_valid), 64'd0);
    endtask

    // Directed sequence covering reset, arithmetic, sign rules, divide-by-zero, backpressure and reset abort.
    initial begin
        int edges;
        int sawValid;
        int popSeen;
        int unstable;

        rst = 1'b1;
        applyStimulus(OP_DIVU, 32'd1, 32'd1, 3'd0);
        #1;
        checkOutput("reset.pop", 64'(in_pop), 64'd0);
        nextCycle();
        nextCycle();
        checkOutput("reset.pop2", 64'(in_pop), 64'd0);
        in_valid = 1'b0;
        nextCycle();
        rst = 1'b0;
        checkOutput("reset.valid", 64'(wb_valid), 64'd0);
        checkOutput("reset.rd", 64'(wb_rd), 64'd0);
        checkOutput("reset.id", 64'(wb_id), 64'd0);
        nextCycle();

        // DIVU 100/7 followed by REMU 100/7 popped on the ack cycle.
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 3'd1);
        #1;
        checkOutput("b2b.pop1", 64'(in_pop), 64'd1);
        nextCycle();
        applyStimulus(OP_REMU, 32'd100, 32'd7, 3'd2);
        popSeen = 0;
        edges = 0;
        while (!wb_valid && edges < 100) begin
            if (in_pop) popSeen++;
            nextCycle();
            edges++;
        end
        checkOutput("b2b.busyNoPop", 64'(popSeen), 64'd0);
        checkOutput("b2b.lat1", 64'(edges), 64'd32);
        checkOutput("b2b.rd1", 64'(wb_rd), 64'd14);
        checkOutput("b2b.id1", 64'(wb_id), 64'd1);
        wb_ack = 1'b1;
        #1;
        checkOutput("b2b.popOnAck", 64'(in_pop), 64'd1);
        nextCycle();
        wb_ack = 1'b0;
        in_valid = 1'b0;
        checkOutput("b2b.validDrop", 64'(wb_valid), 64'd0);
        waitResult(edges);
        checkOutput("b2b.lat2", 64'(edges), 64'd32);
        checkOutput("b2b.rd2", 64'(wb_rd), 64'd2);
        checkOutput("b2b.id2", 64'(wb_id), 64'd2);
        wb_ack = 1'b1;
        nextCycle();
        wb_ack = 1'b0;

        // Signed rules.
        doOp("divNeg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 3'd3, 32'hFFFF_FFFD);
        doOp("remNeg", OP_REM, 32'hFFFF_FFF9, 32'd2, 3'd4, 32'hFFFF_FFFF);
        doOp("divNegDvs", OP_DIV, 32'd7, 32'hFFFF_FFFE, 3'd5, 32'hFFFF_FFFD);
        doOp("remNegDvs", OP_REM, 32'd7, 32'hFFFF_FFFE, 3'd6, 32'd1);

        // Divide by zero fast path.
        doOp("divuZero", OP_DIVU, 32'd5, 32'd0, 3'd7, 32'hFFFF_FFFF);
        doOp("remZero", OP_REM, 32'hFFFF_FFFB, 32'd0, 3'd1, 32'hFFFF_FFFB);
        doOp("divZero", OP_DIV, 32'hFFFF_FFFB, 32'd0, 3'd2, 32'hFFFF_FFFF);

        // Signed overflow.
        doOp("ovfDiv", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 3'd3, 32'h8000_0000);
        doOp("ovfRem", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 32'd0);

        // Backpressure: hold ack low with a waiting request.
        applyStimulus(OP_DIVU, 32'd5, 32'd0, 3'd5);
        nextCycle();
        applyStimulus(OP_DIVU, 32'd9, 32'd3, 3'd6);
        checkOutput("bp.valid", 64'(wb_valid), 64'd1);
        popSeen = 0;
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            if (in_pop) popSeen++;
            if (wb_rd !== 32'hFFFF_FFFF || wb_id !== 3'd5 || wb_valid !== 1'b1) unstable++;
            nextCycle();
        end
        checkOutput("bp.noPop", 64'(popSeen), 64'd0);
        checkOutput("bp.stable", 64'(unstable), 64'd0);
        wb_ack = 1'b1;
        #1;
        checkOutput("bp.popOnAck", 64'(in_pop), 64'd1);
        nextCycle();
        wb_ack = 1'b0;
        in_valid = 1'b0;
        waitResult(edges);
        checkOutput("bp.lat", 64'(edges), 64'd32);
        checkOutput("bp.rd", 64'(wb_rd), 64'd3);
        checkOutput("bp.id", 64'(wb_id), 64'd6);
        wb_ack = 1'b1;
        nextCycle();
        wb_ack = 1'b0;

        // Reset ten cycles after a pop discards the request.
        applyStimulus(OP_DIVU, 32'd1000, 32'd10, 3'd3);
        #1;
        checkOutput("rstMid.pop", 64'(in_pop), 64'd1);
        nextCycle();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) nextCycle();
        rst = 1'b1;
        applyStimulus(OP_DIVU, 32'd1000, 32'd10, 3'd3);
        #1;
        checkOutput("rstMid.noPop", 64'(in_pop), 64'd0);
        in_valid = 1'b0;
        nextCycle();
        rst = 1'b0;
        sawValid = 0;
        for (int i = 0; i < 40; i++) begin
            if (wb_valid) sawValid++;
            nextCycle();
        end
        checkOutput("rstMid.noValid", 64'(sawValid), 64'd0);
        doOp("afterRst", OP_DIVU, 32'd1000, 32'd10, 3'd2, 32'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
